// File: rtl/freq_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module : freq_comp_pkg
// Brief  : Shared state encoding and timing helpers for freq_window_comp.
// Rev    : 1.0  initial release
// ============================================================================
package freq_comp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_COMPARE = 2'd3
   } state_t;

   // One result every settle + window + compare cycles while enabled.
   function automatic int result_period(input int settle_cyc, input int window_cyc);
      return settle_cyc + window_cyc + 1;
   endfunction

   localparam int RESULT_PERIOD_DEF = result_period(10, 40);

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module : sync_edge_det
// Brief  : Two-flop synchroniser plus history flop; one-cycle rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
module sync_edge_det (
   input  logic REF_Clk,
   input  logic Reset,
   input  logic i_async,
   output logic o_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_hist;

   always_ff @(posedge REF_Clk or posedge Reset) begin
      if (Reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
      end else begin
         r_sync1 <= i_async;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign o_edge = r_sync2 & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/freq_window_comp.sv
`default_nettype none
// ============================================================================
// Module : freq_window_comp
// Brief  : Windowed DDS-versus-reference frequency comparator with lock detect.
// Rev    : 1.0  initial release
// ============================================================================
module freq_window_comp
   import freq_comp_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 10,
   parameter int WINDOW_CYC = 40,
   parameter int REF_DIV    = 4,
   parameter int TOL        = 1,
   parameter int LOCK_N     = 4
) (
   input  logic             REF_Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             DDS_Out,
   output logic             Slow,
   output logic             Fast,
   output logic             Locked,
   output logic             Valid,
   output logic [CNT_W-1:0] Ref_Count,
   output logic [CNT_W-1:0] Dds_Count
);

   localparam int c_period = result_period(SETTLE_CYC, WINDOW_CYC);
   localparam int c_tmr_w  = $clog2(c_period + 1);
   localparam int c_div_w  = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
   localparam int c_lock_w = $clog2(LOCK_N + 1);

   localparam logic [c_tmr_w-1:0]  c_settle_last = c_tmr_w'(SETTLE_CYC - 1);
   localparam logic [c_tmr_w-1:0]  c_window_last = c_tmr_w'(WINDOW_CYC - 1);
   localparam logic [c_div_w-1:0]  c_div_last    = c_div_w'(REF_DIV - 1);
   localparam logic [c_lock_w-1:0] c_lock_max    = c_lock_w'(LOCK_N);
   localparam logic [CNT_W:0]      c_tol         = (CNT_W + 1)'(TOL);

   if ((WINDOW_CYC >> CNT_W) != 0) begin : g_chk_window
      $error("freq_window_comp: WINDOW_CYC must be below 2**CNT_W");
   end
   if (REF_DIV < 1) begin : g_chk_div
      $error("freq_window_comp: REF_DIV must be at least 1");
   end
   if (LOCK_N < 1) begin : g_chk_lock
      $error("freq_window_comp: LOCK_N must be at least 1");
   end

   state_t              r_state;
   logic                r_arm;
   logic [c_tmr_w-1:0]  r_tmr;
   logic [c_div_w-1:0]  r_presc;
   logic [CNT_W-1:0]    r_ref_cnt;
   logic [CNT_W-1:0]    r_dds_cnt;
   logic [c_lock_w-1:0] r_lock_cnt;
   logic                r_slow;
   logic                r_fast;
   logic                r_locked;
   logic                r_valid;
   logic [CNT_W-1:0]    r_ref_out;
   logic [CNT_W-1:0]    r_dds_out;

   logic                w_edge;
   logic [CNT_W:0]      w_ref_ext;
   logic [CNT_W:0]      w_dds_ext;
   logic                w_slow;
   logic                w_fast;
   logic [c_lock_w-1:0] w_lock_next;

   sync_edge_det u_sync (
      .REF_Clk (REF_Clk),
      .Reset   (Reset),
      .i_async (DDS_Out),
      .o_edge  (w_edge)
   );

   // One extra bit keeps count+TOL from wrapping.
   assign w_ref_ext   = {1'b0, r_ref_cnt};
   assign w_dds_ext   = {1'b0, r_dds_cnt};
   assign w_slow      = (w_dds_ext + c_tol) < w_ref_ext;
   assign w_fast      = w_dds_ext > (w_ref_ext + c_tol);
   assign w_lock_next = (w_slow || w_fast)           ? '0 :
                        (r_lock_cnt == c_lock_max)   ? c_lock_max :
                                                       r_lock_cnt + c_lock_w'(1);

   always_ff @(posedge REF_Clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_arm      <= 1'b0;
         r_tmr      <= '0;
         r_presc    <= '0;
         r_ref_cnt  <= '0;
         r_dds_cnt  <= '0;
         r_lock_cnt <= '0;
         r_slow     <= 1'b0;
         r_fast     <= 1'b0;
         r_locked   <= 1'b0;
         r_valid    <= 1'b0;
         r_ref_out  <= '0;
         r_dds_out  <= '0;
      end else begin
         r_valid <= 1'b0;
         if (r_state != ST_IDLE && !Enable) begin
            // Abandon the window; the partial counts are never reported.
            r_state    <= ST_IDLE;
            r_arm      <= 1'b0;
            r_tmr      <= '0;
            r_presc    <= '0;
            r_ref_cnt  <= '0;
            r_dds_cnt  <= '0;
            r_lock_cnt <= '0;
            r_slow     <= 1'b0;
            r_fast     <= 1'b0;
            r_locked   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_tmr     <= '0;
                  r_presc   <= '0;
                  r_ref_cnt <= '0;
                  r_dds_cnt <= '0;
                  if (r_arm && Enable) begin
                     r_state <= ST_SETTLE;
                     r_arm   <= 1'b0;
                  end else begin
                     r_arm   <= Enable;
                  end
               end
               ST_SETTLE: begin
                  r_presc   <= '0;
                  r_ref_cnt <= '0;
                  r_dds_cnt <= '0;
                  if (r_tmr == c_settle_last) begin
                     r_tmr   <= '0;
                     r_state <= ST_MEASURE;
                  end else begin
                     r_tmr   <= r_tmr + c_tmr_w'(1);
                  end
               end
               ST_MEASURE: begin
                  if (r_presc == c_div_last) begin
                     r_presc   <= '0;
                     r_ref_cnt <= r_ref_cnt + CNT_W'(1);
                  end else begin
                     r_presc   <= r_presc + c_div_w'(1);
                  end
                  if (w_edge) begin
                     r_dds_cnt <= r_dds_cnt + CNT_W'(1);
                  end
                  if (r_tmr == c_window_last) begin
                     r_tmr   <= '0;
                     r_state <= ST_COMPARE;
                  end else begin
                     r_tmr   <= r_tmr + c_tmr_w'(1);
                  end
               end
               ST_COMPARE: begin
                  r_valid    <= 1'b1;
                  r_ref_out  <= r_ref_cnt;
                  r_dds_out  <= r_dds_cnt;
                  r_slow     <= w_slow;
                  r_fast     <= w_fast;
                  r_lock_cnt <= w_lock_next;
                  r_locked   <= (w_lock_next == c_lock_max);
                  r_tmr      <= '0;
                  r_presc    <= '0;
                  r_ref_cnt  <= '0;
                  r_dds_cnt  <= '0;
                  r_state    <= ST_SETTLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign Slow      = r_slow;
   assign Fast      = r_fast;
   assign Locked    = r_locked;
   assign Valid     = r_valid;
   assign Ref_Count = r_ref_out;
   assign Dds_Count = r_dds_out;

endmodule
`default_nettype wire

// File: tb/tb_freq_window_comp.sv
`default_nettype none
// ============================================================================
// Module : tb_freq_window_comp
// Brief  : Directed scoreboard bench for freq_window_comp at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_freq_window_comp;

   typedef struct {
      int ref_cnt;
      int dds_lo;
      int dds_hi;
      int slow;
      int fast;
      int locked;
      int gap;
   } exp_t;

   logic        clk;
   logic        Reset;
   logic        Enable;
   logic        DDS_Out;
   logic        Slow;
   logic        Fast;
   logic        Locked;
   logic        Valid;
   logic [15:0] Ref_Count;
   logic [15:0] Dds_Count;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   ref_cyc = 0;
   int   dds_per = 0;
   exp_t q[$];

   freq_window_comp dut (
      .REF_Clk   (clk),
      .Reset     (Reset),
      .Enable    (Enable),
      .DDS_Out   (DDS_Out),
      .Slow      (Slow),
      .Fast      (Fast),
      .Locked    (Locked),
      .Valid     (Valid),
      .Ref_Count (Ref_Count),
      .Dds_Count (Dds_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int r, input int lo, input int hi, input int s,
                       input int f, input int l, input int g);
      exp_t e;
      e.ref_cnt = r; e.dds_lo = lo; e.dds_hi = hi;
      e.slow = s; e.fast = f; e.locked = l; e.gap = g;
      q.push_back(e);
   endtask

   task automatic wait_valid(input int n);
      for (int k = 0; k < n; k++) begin
         int seen;
         seen = 0;
         for (int t = 0; t < 120 && seen == 0; t++) begin
            @(negedge clk);
            if (Valid === 1'b1) seen = 1;
         end
         chk("valid_timeout", 32'(seen), 32'd1);
      end
   endtask

   // DDS stimulus: one-cycle high pulse every dds_per cycles, or held low.
   initial begin
      int ph;
      ph = 0;
      DDS_Out = 1'b0;
      forever begin
         @(negedge clk);
         if (dds_per == 0) begin
            DDS_Out = 1'b0;
            ph = 0;
         end else begin
            DDS_Out = (ph == 0);
            ph = (ph + 1) % dds_per;
         end
      end
   end

   // Scoreboard: every Valid pops one expected result.
   always @(negedge clk) begin
      if (Valid === 1'b1) begin
         chk("valid_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ref_count", 32'(Ref_Count), 32'(e.ref_cnt));
            chk("dds_in_range", 32'(Dds_Count >= 16'(e.dds_lo) && Dds_Count <= 16'(e.dds_hi)), 32'd1);
            chk("slow", 32'(Slow), 32'(e.slow));
            chk("fast", 32'(Fast), 32'(e.fast));
            chk("locked", 32'(Locked), 32'(e.locked));
            chk("valid_gap", 32'(cyc - ref_cyc), 32'(e.gap));
         end
         ref_cyc = cyc;
      end
   end

   initial begin
      Reset  = 1'b1;
      Enable = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(Valid), 32'd0);
      chk("rst_slow", 32'(Slow), 32'd0);
      chk("rst_fast", 32'(Fast), 32'd0);
      chk("rst_locked", 32'(Locked), 32'd0);
      chk("rst_ref", 32'(Ref_Count), 32'd0);
      chk("rst_dds", 32'(Dds_Count), 32'd0);
      Reset = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal: in-band, lock on the fourth result.
      dds_per = 4;
      Enable  = 1'b1;
      ref_cyc = cyc + 1;
      push(10, 10, 10, 0, 0, 0, 52);
      push(10, 10, 10, 0, 0, 0, 51);
      push(10, 10, 10, 0, 0, 0, 51);
      push(10, 10, 10, 0, 0, 1, 51);
      wait_valid(4);

      // One fast window drops lock, four in-band windows regain it.
      dds_per = 3;
      push(10, 13, 14, 0, 1, 0, 51);
      wait_valid(1);
      dds_per = 4;
      push(10, 10, 10, 0, 0, 0, 51);
      push(10, 10, 10, 0, 0, 0, 51);
      push(10, 10, 10, 0, 0, 0, 51);
      push(10, 10, 10, 0, 0, 1, 51);
      wait_valid(4);

      // DDS stuck low.
      dds_per = 0;
      push(10, 0, 0, 1, 0, 0, 51);
      wait_valid(1);

      // Fast window, then Enable dropped at MEASURE cycle 20.
      dds_per = 3;
      push(10, 13, 14, 0, 1, 0, 51);
      wait_valid(1);
      dds_per = 4;
      repeat (29) @(negedge clk);
      Enable = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(Valid), 32'd0);
      chk("abort_fast", 32'(Fast), 32'd0);
      chk("abort_slow", 32'(Slow), 32'd0);
      chk("abort_locked", 32'(Locked), 32'd0);
      repeat (60) @(negedge clk);
      Enable  = 1'b1;
      ref_cyc = cyc + 1;
      push(10, 10, 10, 0, 0, 0, 52);
      wait_valid(1);

      // Asynchronous reset in the middle of MEASURE.
      repeat (25) @(negedge clk);
      #3 Reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(Valid), 32'd0);
      chk("mid_rst_ref", 32'(Ref_Count), 32'd0);
      chk("mid_rst_dds", 32'(Dds_Count), 32'd0);
      chk("mid_rst_slow", 32'(Slow), 32'd0);
      chk("mid_rst_fast", 32'(Fast), 32'd0);
      chk("mid_rst_locked", 32'(Locked), 32'd0);
      q.delete();
      @(negedge clk);
      Reset   = 1'b0;
      ref_cyc = cyc + 1;
      push(10, 10, 10, 0, 0, 0, 52);
      wait_valid(1);

      repeat (5) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
